axis_ipsa_bridge: RTL and testbench
===================================

Name: axis_ipsa_bridge

Overview:
Parametrised AXI-Stream-to-IPSA bridge for the packet-processing path, sitting between the network/host stream and the IPSA pipeline. Ingress packs S_DATA_W-wide AXIS beats into IPSA_W-wide IPSA words and issues them on the enable/data interface. Egress re-attaches the per-word tkeep/tlast sideband to IPSA results, in order, and buffers the results for a backpressured AXIS master. A credit counter throttles ingress so that IPSA output, which cannot be stalled, never overflows the egress buffer.

Parameters:
S_DATA_W, 512, ingress AXIS data width in bits; multiple of 8.
IPSA_W, 1024, IPSA word and egress AXIS data width; IPSA_W = R*S_DATA_W with R a power of two >= 1.
FIFO_DEPTH, 16, entries in each of the metadata FIFO and the output FIFO; power of two >= 2.

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  reset, asynchronous, active-low
s_axis_tvalid  in  1  ingress valid
s_axis_tready  out  1  ingress ready
s_axis_tdata  in  S_DATA_W  ingress data
s_axis_tkeep  in  S_DATA_W/8  ingress byte enables
s_axis_tlast  in  1  ingress end of packet
ipsa_io_en_in  out  1  IPSA word strobe
ipsa_io_data_in  out  IPSA_W  IPSA word
ipsa_io_en_out  in  1  IPSA result strobe
ipsa_io_data_out  in  IPSA_W  IPSA result word
m_axis_tvalid  out  1  egress valid
m_axis_tready  in  1  egress ready
m_axis_tdata  out  IPSA_W  egress data
m_axis_tkeep  out  IPSA_W/8  egress byte enables
m_axis_tlast  out  1  egress end of packet
credit_cnt  out  log2(FIFO_DEPTH)+1  words outstanding (in IPSA or in output FIFO)
err_orphan  out  1  sticky: IPSA result arrived with metadata FIFO empty
pkt_in_cnt  out  32  packets accepted (tlast beats), wraps
pkt_out_cnt  out  32  packets delivered (tlast handshakes), wraps

Behaviour:
- Reset (ap_rst_n low, asynchronous): all outputs 0, including s_axis_tready; lane index, FIFOs, credit counter, error flag and packet counters cleared. Reset mid-packet discards the partial word and all buffered words. s_axis_tready rises on the first ap_clk edge after deassertion.
- s_axis_tready = (credit_cnt < FIFO_DEPTH), registered-free combinational from the counter.
- Packer: lane index idx in 0..R-1. An accepted beat writes data at [idx*S_DATA_W +: S_DATA_W] and keep into the matching lane. Word completes on tlast or idx==R-1; idx then returns to 0, otherwise it increments.
- Unfilled lanes of a completed word carry zero data and zero keep. Lane registers are cleared after each issue.
- Issue: the cycle after a completing beat, ipsa_io_en_in=1 for exactly one cycle with the packed word (latency 1). Otherwise ipsa_io_en_in=0 and ipsa_io_data_in holds its last value.
- The metadata entry {keep[IPSA_W/8], last} is pushed on the completing-beat cycle.
- Credits: +1 on a completing-beat accept; -1 on an m_axis handshake; a simultaneous +1/-1 leaves the count unchanged. The count never exceeds FIFO_DEPTH, so neither FIFO overflows.
- Egress: on ipsa_io_en_out=1, pop the metadata head and push {ipsa_io_data_out, keep, last} into the output FIFO in the same cycle.
- If the metadata FIFO is empty when ipsa_io_en_out=1: the result is dropped, err_orphan is set and held until reset, and credits are unchanged.
- Push and pop of the metadata FIFO in the same cycle are both legal, including when it is empty-then-pushed: a push on the same edge does not satisfy the pop.
- Output FIFO is first-word-fall-through: m_axis_tvalid = not empty, and tdata/tkeep/tlast come from the head. The head pops on tvalid & tready. A push and a pop in the same cycle are legal at any occupancy.
- AXIS master rule: once m_axis_tvalid is asserted, tdata/tkeep/tlast remain stable until the handshake.
- IPSA results are in order and carry no sideband. The IPSA latency is arbitrary but fixed per word order; the bridge does not depend on its value.
- pkt_in_cnt +1 per accepted s_axis beat with tlast. pkt_out_cnt +1 per m_axis handshake with tlast. Both wrap modulo 2^32.

Test Plan:
- R=2, DEPTH=4, IPSA modelled as 3-cycle delay loopback. Send a 2-beat packet (A, B, keep all-ones, tlast on B) -> ipsa_io_en_in one cycle after B with data {B,A}. m_axis delivers {B,A}, tkeep all-ones, tlast=1. pkt_in_cnt=pkt_out_cnt=1.
- Send a 1-beat packet C with tlast and keep=0x0000_0000_0000_00FF -> IPSA word {0,C}. m_axis_tkeep low 8 bits = 1, upper 120 bits = 0. tlast=1.
- Hold m_axis_tready=0 and stream 6 full words -> credit_cnt saturates at 4 and s_axis_tready=0. Exactly 4 words are issued. Releasing tready delivers 4 words in order, then the remaining 2.
- With m_axis_tready=1 throughout, credit_cnt settles at a stable value: simultaneous accept and pop keep it constant, and no bubble is added by the bridge.
- Pulse ipsa_io_en_out with no word issued -> err_orphan=1 and stays 1. m_axis_tvalid stays 0. credit_cnt stays 0.
- Assert ap_rst_n=0 asynchronously mid-packet with 3 words buffered -> all outputs 0 immediately, without a clock edge. After release, a new 2-beat packet passes cleanly and counters restart from 0.

Source files
------------

// File: rtl/axis_ipsa_bridge.sv
// AXI-Stream to IPSA bridge.
// Ingress packs narrow AXIS beats into IPSA words and strobes them into the IPSA pipeline.
// Egress pairs each IPSA result with the tkeep/tlast captured at ingress. Pairing is
// strictly in order. Results are buffered for a backpressured AXIS master.
// A credit count covers every word that is inside IPSA or in the output FIFO. Ingress
// stalls when all credits are taken, so the unstallable IPSA output always has room.
module axis_ipsa_bridge #(
    parameter int S_DATA_W   = 512,
    parameter int IPSA_W     = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [S_DATA_W-1:0]           s_axis_tdata,
    input  logic [S_DATA_W/8-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tlast,
    output logic                          ipsa_io_en_in,
    output logic [IPSA_W-1:0]             ipsa_io_data_in,
    input  logic                          ipsa_io_en_out,
    input  logic [IPSA_W-1:0]             ipsa_io_data_out,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [IPSA_W-1:0]             m_axis_tdata,
    output logic [IPSA_W/8-1:0]           m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   credit_cnt,
    output logic                          err_orphan,
    output logic [31:0]                   pkt_in_cnt,
    output logic [31:0]                   pkt_out_cnt
);

    localparam int R     = IPSA_W / S_DATA_W;
    localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
    localparam int SK_W  = S_DATA_W / 8;
    localparam int KW    = IPSA_W / 8;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(R - 1);
    localparam logic [CW-1:0]    CREDIT_MAX = CW'(FIFO_DEPTH);

    logic              ready_en;
    logic [IDX_W-1:0]  idx;
    logic [IPSA_W-1:0] lane_data;
    logic [KW-1:0]     lane_keep;
    logic [IPSA_W-1:0] pk_data;
    logic [KW-1:0]     pk_keep;
    logic              accept;
    logic              complete;

    logic [KW-1:0]     meta_keep_mem [FIFO_DEPTH];
    logic              meta_last_mem [FIFO_DEPTH];
    logic [PW-1:0]     meta_wr;
    logic [PW-1:0]     meta_rd;
    logic [CW-1:0]     meta_cnt;
    logic              meta_push;
    logic              meta_pop;
    logic              orphan;

    logic [IPSA_W-1:0] out_data_mem [FIFO_DEPTH];
    logic [KW-1:0]     out_keep_mem [FIFO_DEPTH];
    logic              out_last_mem [FIFO_DEPTH];
    logic [PW-1:0]     out_wr;
    logic [PW-1:0]     out_rd;
    logic [CW-1:0]     out_cnt;
    logic              out_push;
    logic              out_pop;

    // ready_en holds tready low during reset and releases it on the first edge afterwards
    assign s_axis_tready = ready_en && (credit_cnt < CREDIT_MAX);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign complete      = accept & (s_axis_tlast | (idx == IDX_LAST));

    assign meta_push = complete;
    assign meta_pop  = ipsa_io_en_out & (meta_cnt != '0);
    assign orphan    = ipsa_io_en_out & (meta_cnt == '0);
    assign out_push  = meta_pop;
    assign out_pop   = m_axis_tvalid & m_axis_tready;

    // FWFT head; data lanes read as zero while empty, so reset shows zeros without clearing storage
    assign m_axis_tvalid = (out_cnt != '0);
    assign m_axis_tdata  = m_axis_tvalid ? out_data_mem[out_rd] : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? out_keep_mem[out_rd] : '0;
    assign m_axis_tlast  = m_axis_tvalid & out_last_mem[out_rd];

    // Overlay the incoming beat onto the current lane index
    always_comb begin
        pk_data = lane_data;
        pk_keep = lane_keep;
        for (int i = 0; i < R; i++) begin
            if (idx == IDX_W'(i)) begin
                pk_data[i*S_DATA_W +: S_DATA_W] = s_axis_tdata;
                pk_keep[i*SK_W +: SK_W]         = s_axis_tkeep;
            end
        end
    end

    // Packer: accumulate lanes, issue the completed word one cycle after its last beat
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ready_en        <= 1'b0;
            idx             <= '0;
            lane_data       <= '0;
            lane_keep       <= '0;
            ipsa_io_en_in   <= 1'b0;
            ipsa_io_data_in <= '0;
        end else begin
            ready_en      <= 1'b1;
            ipsa_io_en_in <= complete;
            if (accept) begin
                if (complete) begin
                    ipsa_io_data_in <= pk_data;
                    lane_data       <= '0;
                    lane_keep       <= '0;
                    idx             <= '0;
                end else begin
                    lane_data <= pk_data;
                    lane_keep <= pk_keep;
                    idx       <= idx + 1'b1;
                end
            end
        end
    end

    // Metadata FIFO storage; the keep of the word is exactly the packed keep
    always_ff @(posedge ap_clk) begin
        if (meta_push) begin
            meta_keep_mem[meta_wr] <= pk_keep;
            meta_last_mem[meta_wr] <= s_axis_tlast;
        end
    end

    // Metadata FIFO pointers; pop is judged on pre-edge occupancy, so a same-edge push never feeds it
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            meta_wr  <= '0;
            meta_rd  <= '0;
            meta_cnt <= '0;
        end else begin
            if (meta_push) meta_wr <= meta_wr + 1'b1;
            if (meta_pop)  meta_rd <= meta_rd + 1'b1;
            case ({meta_push, meta_pop})
                2'b10:   meta_cnt <= meta_cnt + 1'b1;
                2'b01:   meta_cnt <= meta_cnt - 1'b1;
                default: meta_cnt <= meta_cnt;
            endcase
        end
    end

    // Output FIFO storage: IPSA result joined with its ingress sideband
    always_ff @(posedge ap_clk) begin
        if (out_push) begin
            out_data_mem[out_wr] <= ipsa_io_data_out;
            out_keep_mem[out_wr] <= meta_keep_mem[meta_rd];
            out_last_mem[out_wr] <= meta_last_mem[meta_rd];
        end
    end

    // Output FIFO pointers; the credit limit keeps occupancy within depth
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_wr  <= '0;
            out_rd  <= '0;
            out_cnt <= '0;
        end else begin
            if (out_push) out_wr <= out_wr + 1'b1;
            if (out_pop)  out_rd <= out_rd + 1'b1;
            case ({out_push, out_pop})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // Credits: taken when a word completes, returned when it leaves on m_axis
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            credit_cnt <= '0;
        end else begin
            case ({complete, out_pop})
                2'b10:   credit_cnt <= credit_cnt + 1'b1;
                2'b01:   credit_cnt <= credit_cnt - 1'b1;
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // Sticky orphan flag and wrapping packet counters
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_orphan  <= 1'b0;
            pkt_in_cnt  <= '0;
            pkt_out_cnt <= '0;
        end else begin
            if (orphan) err_orphan <= 1'b1;
            if (accept && s_axis_tlast) pkt_in_cnt <= pkt_in_cnt + 32'd1;
            if (out_pop && m_axis_tlast) pkt_out_cnt <= pkt_out_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_axis_ipsa_bridge.sv
// Bench for axis_ipsa_bridge: R=2, depth 4, IPSA modelled as a 3-cycle loopback.
// A queue-based model predicts every output each cycle; directed steps add literal checks.
module tb_axis_ipsa_bridge;

    localparam int SW    = 512;
    localparam int IW    = 1024;
    localparam int DEPTH = 4;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n = 1'b0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [SW-1:0]   s_axis_tdata = '0;
    logic [SW/8-1:0] s_axis_tkeep = '0;
    logic            s_axis_tlast = 1'b0;
    logic            ipsa_io_en_in;
    logic [IW-1:0]   ipsa_io_data_in;
    logic            ipsa_io_en_out;
    logic [IW-1:0]   ipsa_io_data_out;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic [IW-1:0]   m_axis_tdata;
    logic [IW/8-1:0] m_axis_tkeep;
    logic            m_axis_tlast;
    logic [2:0]      credit_cnt;
    logic            err_orphan;
    logic [31:0]     pkt_in_cnt;
    logic [31:0]     pkt_out_cnt;

    axis_ipsa_bridge #(.S_DATA_W(SW), .IPSA_W(IW), .FIFO_DEPTH(DEPTH)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .ipsa_io_en_in(ipsa_io_en_in), .ipsa_io_data_in(ipsa_io_data_in),
        .ipsa_io_en_out(ipsa_io_en_out), .ipsa_io_data_out(ipsa_io_data_out),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .credit_cnt(credit_cnt), .err_orphan(err_orphan),
        .pkt_in_cnt(pkt_in_cnt), .pkt_out_cnt(pkt_out_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // IPSA stand-in: fixed 3-cycle delay, flushed by reset, plus an injectable stray strobe
    logic [2:0]    pipe_v;
    logic [IW-1:0] pipe_d [3];
    logic          orphan_pulse = 1'b0;

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < 3; i++) pipe_d[i] <= '0;
        end else begin
            pipe_v    <= {pipe_v[1:0], ipsa_io_en_in};
            pipe_d[0] <= ipsa_io_data_in;
            pipe_d[1] <= pipe_d[0];
            pipe_d[2] <= pipe_d[1];
        end
    end

    assign ipsa_io_en_out   = pipe_v[2] | orphan_pulse;
    assign ipsa_io_data_out = pipe_d[2];

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [IW/8-1:0] k; logic l; } meta_t;
    typedef struct packed { logic [IW-1:0] d; logic [IW/8-1:0] k; logic l; } out_t;

    bit              m_rdy_en = 0;
    int              m_credit = 0;
    bit              m_err = 0;
    int unsigned     m_pin = 0;
    int unsigned     m_pout = 0;
    bit              m_en_in = 0;
    logic [IW-1:0]   m_ipsa_d = '0;
    logic [SW-1:0]   part_d[$];
    logic [SW/8-1:0] part_k[$];
    meta_t           meta_q[$];
    out_t            out_q[$];
    int              issued_cnt = 0;

    always @(negedge ap_clk) begin : compare
        bit              exp_rdy;
        bit              exp_v;
        bit              acc;
        bit              hs;
        bit              new_en;
        meta_t           mt;
        out_t            o;
        logic [IW-1:0]   w;
        logic [IW/8-1:0] wk;

        if (!ap_rst_n) begin
            m_rdy_en = 0; m_credit = 0; m_err = 0; m_pin = 0; m_pout = 0;
            m_en_in = 0; m_ipsa_d = '0;
            part_d.delete(); part_k.delete(); meta_q.delete(); out_q.delete();
        end

        exp_rdy = m_rdy_en && (m_credit < DEPTH);
        exp_v   = (out_q.size() != 0);
        chk("tready", s_axis_tready, exp_rdy);
        chk("en_in", ipsa_io_en_in, m_en_in);
        chk("ipsa_lo", ipsa_io_data_in[511:0], m_ipsa_d[511:0]);
        chk("ipsa_hi", ipsa_io_data_in[1023:512], m_ipsa_d[1023:512]);
        chk("tvalid", m_axis_tvalid, exp_v);
        if (exp_v) begin
            chk("tdata_lo", m_axis_tdata[511:0], out_q[0].d[511:0]);
            chk("tdata_hi", m_axis_tdata[1023:512], out_q[0].d[1023:512]);
            chk("tkeep", m_axis_tkeep, out_q[0].k);
            chk("tlast", m_axis_tlast, out_q[0].l);
        end
        chk("credit", credit_cnt, m_credit);
        chk("err_orphan", err_orphan, m_err);
        chk("pkt_in", pkt_in_cnt, m_pin);
        chk("pkt_out", pkt_out_cnt, m_pout);
        if (ipsa_io_en_in) issued_cnt++;

        if (ap_rst_n) begin
            acc    = s_axis_tvalid && exp_rdy;
            hs     = exp_v && m_axis_tready;
            new_en = 0;
            if (hs) begin
                if (out_q[0].l) m_pout++;
                void'(out_q.pop_front());
                m_credit--;
            end
            if (ipsa_io_en_out) begin
                if (meta_q.size() == 0) begin
                    m_err = 1;
                end else begin
                    mt  = meta_q.pop_front();
                    o.d = ipsa_io_data_out;
                    o.k = mt.k;
                    o.l = mt.l;
                    out_q.push_back(o);
                end
            end
            if (acc) begin
                part_d.push_back(s_axis_tdata);
                part_k.push_back(s_axis_tkeep);
                if (s_axis_tlast) m_pin++;
                if (s_axis_tlast || part_d.size() == IW / SW) begin
                    w  = '0;
                    wk = '0;
                    foreach (part_d[i]) begin
                        w[i*SW +: SW]         = part_d[i];
                        wk[i*(SW/8) +: SW/8]  = part_k[i];
                    end
                    m_ipsa_d = w;
                    new_en   = 1;
                    mt.k     = wk;
                    mt.l     = s_axis_tlast;
                    meta_q.push_back(mt);
                    m_credit++;
                    part_d.delete();
                    part_k.delete();
                end
            end
            m_en_in  = new_en;
            m_rdy_en = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [SW-1:0] pat(input int tag);
        logic [31:0] t;
        t = tag;
        return {16{t}};
    endfunction

    task automatic send_beat(input logic [SW-1:0] d, input logic [SW/8-1:0] k,
                             input bit l, output int stalls);
        bit got;
        int n;
        got = 0;
        n   = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        while (!got && n <= 300) begin
            @(negedge ap_clk);
            got = s_axis_tready;
            @(posedge ap_clk);
            #1;
            if (!got) n++;
        end
        chk("send_accept", got, 1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        stalls = n;
    endtask

    task automatic wait_tvalid();
        int n;
        n = 0;
        do begin
            @(negedge ap_clk);
            n++;
        end while (!m_axis_tvalid && n < 50);
        chk("wait_tvalid", m_axis_tvalid, 1);
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        do begin
            @(negedge ap_clk);
            n++;
        end while (credit_cnt != 0 && n < 200);
        chk("wait_drained", credit_cnt, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [SW-1:0] a, b, c;
        int st;
        int total;
        int base;

        a = pat(32'hA0A0_0001);
        b = pat(32'hB0B0_0002);
        c = pat(32'hC0C0_0003);

        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_credit", credit_cnt, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        // two-beat packet A,B
        send_beat(a, '1, 0, st);
        send_beat(b, '1, 1, st);
        chk("t1_en_in", ipsa_io_en_in, 1);
        chk("t1_ipsa_lo", ipsa_io_data_in[511:0], a);
        chk("t1_ipsa_hi", ipsa_io_data_in[1023:512], b);
        wait_tvalid();
        chk("t1_tdata_lo", m_axis_tdata[511:0], a);
        chk("t1_tdata_hi", m_axis_tdata[1023:512], b);
        chk("t1_tkeep", m_axis_tkeep, {128{1'b1}});
        chk("t1_tlast", m_axis_tlast, 1);
        @(posedge ap_clk); #1;
        chk("t1_pkt_in", pkt_in_cnt, 1);
        chk("t1_pkt_out", pkt_out_cnt, 1);

        // one-beat packet C, partial keep
        send_beat(c, 64'hFF, 1, st);
        chk("t2_ipsa_lo", ipsa_io_data_in[511:0], c);
        chk("t2_ipsa_hi", ipsa_io_data_in[1023:512], 0);
        wait_tvalid();
        chk("t2_tkeep", m_axis_tkeep, 128'hFF);
        chk("t2_tlast", m_axis_tlast, 1);
        @(posedge ap_clk); #1;

        // backpressure: six words against four credits
        m_axis_tready = 1'b0;
        base = issued_cnt;
        fork
            begin
                for (int w = 0; w < 6; w++) begin
                    send_beat(pat(32'h1000_0000 + w), '1, 0, st);
                    send_beat(pat(32'h2000_0000 + w), '1, 1, st);
                end
            end
            begin
                repeat (40) @(negedge ap_clk);
                chk("t3_credit_sat", credit_cnt, 4);
                chk("t3_tready_low", s_axis_tready, 0);
                chk("t3_issued", issued_cnt - base, 4);
                chk("t3_head_lo", m_axis_tdata[511:0], pat(32'h1000_0000));
                @(posedge ap_clk); #1;
                m_axis_tready = 1'b1;
            end
        join
        wait_drained();
        chk("t3_issued_all", issued_cnt - base, 6);
        chk("t3_pkt_in", pkt_in_cnt, 8);
        chk("t3_pkt_out", pkt_out_cnt, 8);

        // streaming with tready high: no ingress stall
        total = 0;
        for (int w = 0; w < 8; w++) begin
            send_beat(pat(32'h3000_0000 + w), '1, 0, st);
            total += st;
            send_beat(pat(32'h4000_0000 + w), '1, (w == 7), st);
            total += st;
        end
        chk("t4_stalls", total, 0);
        wait_drained();

        // orphan result
        @(posedge ap_clk); #1;
        orphan_pulse = 1'b1;
        @(posedge ap_clk); #1;
        orphan_pulse = 1'b0;
        repeat (3) @(negedge ap_clk);
        chk("t5_err", err_orphan, 1);
        chk("t5_tvalid", m_axis_tvalid, 0);
        chk("t5_credit", credit_cnt, 0);
        repeat (5) @(negedge ap_clk);
        chk("t5_err_sticky", err_orphan, 1);

        // asynchronous reset mid-packet with three words buffered
        @(posedge ap_clk); #1;
        m_axis_tready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            send_beat(pat(32'h5000_0000 + w), '1, 0, st);
            send_beat(pat(32'h6000_0000 + w), '1, 1, st);
        end
        repeat (10) @(negedge ap_clk);
        chk("t6_credit3", credit_cnt, 3);
        chk("t6_tvalid", m_axis_tvalid, 1);
        @(posedge ap_clk); #1;
        send_beat(pat(32'h7000_0000), '1, 0, st);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("t6_rst_tready", s_axis_tready, 0);
        chk("t6_rst_tvalid", m_axis_tvalid, 0);
        chk("t6_rst_tdata", m_axis_tdata[511:0], 0);
        chk("t6_rst_en_in", ipsa_io_en_in, 0);
        chk("t6_rst_ipsa", ipsa_io_data_in[511:0], 0);
        chk("t6_rst_credit", credit_cnt, 0);
        chk("t6_rst_err", err_orphan, 0);
        chk("t6_rst_pkt_in", pkt_in_cnt, 0);
        chk("t6_rst_pkt_out", pkt_out_cnt, 0);
        @(posedge ap_clk);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge ap_clk);
        chk("t6_tready_pre_edge", s_axis_tready, 0);
        @(posedge ap_clk); #1;
        chk("t6_tready_post_edge", s_axis_tready, 1);
        send_beat(a, '1, 0, st);
        send_beat(c, '1, 1, st);
        wait_tvalid();
        chk("t6_tdata_lo", m_axis_tdata[511:0], a);
        chk("t6_tdata_hi", m_axis_tdata[1023:512], c);
        @(posedge ap_clk); #1;
        chk("t6_pkt_in", pkt_in_cnt, 1);
        chk("t6_pkt_out", pkt_out_cnt, 1);
        chk("t6_err", err_orphan, 0);

        repeat (5) @(posedge ap_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
